// File: rtl/ttl_priority_interrupt_controller_pkg.sv
// ============================================================================
// ttl_priority_interrupt_controller_pkg
// Shared widths, state codes and priority helpers for the 8-level PIC.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ttl_priority_interrupt_controller_pkg;

  localparam int PIC_WIDTH_IN  = 8;
  localparam int PIC_WIDTH_OUT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACK    = 2'd2
  } pic_state_t;

  typedef struct packed {
    logic                     valid;
    logic [PIC_WIDTH_OUT-1:0] idx;
  } pic_hi_t;

  // Index of the highest set bit; valid=0 stands for "no level" (-1).
  function automatic pic_hi_t pic_highest(input logic [PIC_WIDTH_IN-1:0] v);
    pic_hi_t r;
    r = '0;
    for (int i = 0; i < PIC_WIDTH_IN; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = i[PIC_WIDTH_OUT-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [PIC_WIDTH_IN-1:0] pic_onehot(input logic [PIC_WIDTH_OUT-1:0] idx);
    logic [PIC_WIDTH_IN-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ttl_priority_interrupt_controller_74148.sv
// ============================================================================
// ttl_74148
// 8-to-3 active-low priority encoder (single device, no cascade output).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ttl_74148
  import ttl_priority_interrupt_controller_pkg::*;
(
  input  logic                     i_ei_bar,
  input  logic [PIC_WIDTH_IN-1:0]  i_d_bar,
  output logic [PIC_WIDTH_OUT-1:0] o_a_bar,
  output logic                     o_gs_bar
);

  // Ascending scan so the highest active input wins.
  always_comb begin
    o_a_bar  = '1;
    o_gs_bar = 1'b1;
    if (!i_ei_bar) begin
      for (int i = 0; i < PIC_WIDTH_IN; i++) begin
        if (!i_d_bar[i]) begin
          o_a_bar  = ~i[PIC_WIDTH_OUT-1:0];
          o_gs_bar = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ttl_priority_interrupt_controller.sv
// ============================================================================
// ttl_priority_interrupt_controller
// 8-level priority interrupt controller: request latch, mask, 74148 arbiter,
// in-service nesting and CPU Int/Ack handshake. Optional macro:
// REQUEST_EDGE_TRIGGER_EN (requests pend on falling edges instead of levels).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ttl_priority_interrupt_controller
  import ttl_priority_interrupt_controller_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                     Clk,
  input  logic                     Clear_bar,
  input  logic [PIC_WIDTH_IN-1:0]  Request_bar,
  input  logic                     Mask_Load,
  input  logic [PIC_WIDTH_IN-1:0]  Mask_In,
  input  logic                     Ack_bar,
  input  logic                     EOI_bar,
  output logic                     Int_bar,
  output logic [PIC_WIDTH_OUT-1:0] Y_bar,
  output logic [PIC_WIDTH_IN-1:0]  InService
);

  pic_state_t               r_state;
  pic_state_t               w_state_next;
  logic [PIC_WIDTH_IN-1:0]  r_pending;
  logic [PIC_WIDTH_IN-1:0]  r_mask;
  logic [PIC_WIDTH_IN-1:0]  r_in_service;
  logic [PIC_WIDTH_OUT-1:0] r_vec;
  logic                     r_eoi_sample;

  logic [PIC_WIDTH_IN-1:0]  w_cand;
  logic [PIC_WIDTH_OUT-1:0] w_enc_a_bar;
  logic                     w_enc_gs_bar;
  logic [PIC_WIDTH_OUT-1:0] w_h;
  logic                     w_cand_any;
  pic_hi_t                  w_s;
  logic                     w_eligible;
  logic                     w_ack_take;
  logic                     w_eoi_fall;
  logic [PIC_WIDTH_IN-1:0]  w_req_capture;
  logic [PIC_WIDTH_IN-1:0]  w_pending_next;
  logic [PIC_WIDTH_IN-1:0]  w_in_service_next;
  logic                     w_int_bar;
  logic [PIC_WIDTH_OUT-1:0] w_y_bar;

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
`ifdef REQUEST_EDGE_TRIGGER_EN
  logic [PIC_WIDTH_IN-1:0] r_req_sample;

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_req_sample <= '1;
    end else begin
      r_req_sample <= Request_bar;
    end
  end

  assign w_req_capture = r_req_sample & ~Request_bar;
`else
  assign w_req_capture = ~Request_bar;
`endif

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign w_cand = r_pending & ~r_mask;

  ttl_74148 u_enc (
    .i_ei_bar (1'b0),
    .i_d_bar  (~w_cand),
    .o_a_bar  (w_enc_a_bar),
    .o_gs_bar (w_enc_gs_bar)
  );

  assign w_h        = ~w_enc_a_bar;
  assign w_cand_any = ~w_enc_gs_bar;
  assign w_s        = pic_highest(r_in_service);
  assign w_eligible = w_cand_any && (!w_s.valid || (w_h > w_s.idx));
  assign w_eoi_fall = r_eoi_sample && !EOI_bar;

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ack_take   = 1'b0;
    w_int_bar    = 1'b1;
    w_y_bar      = '1;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        w_int_bar = 1'b0;
        if (!Ack_bar) begin
          w_state_next = ST_ACK;
          w_ack_take   = 1'b1;
        end else if (!w_eligible) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_y_bar = ~r_vec;
        if (Ack_bar) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // EOI retires the pre-edge top level before an acknowledge adds the new one.
  always_comb begin
    w_in_service_next = r_in_service;
    if (w_eoi_fall && w_s.valid) begin
      w_in_service_next = w_in_service_next & ~pic_onehot(w_s.idx);
    end
    if (w_ack_take) begin
      w_in_service_next = w_in_service_next | pic_onehot(w_h);
    end
  end

  // A request still active at the ack edge re-pends its own level.
  always_comb begin
    w_pending_next = r_pending;
    if (w_ack_take) begin
      w_pending_next = w_pending_next & ~pic_onehot(w_h);
    end
    w_pending_next = w_pending_next | w_req_capture;
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_mask       <= '1;
      r_in_service <= '0;
      r_vec        <= '0;
      r_eoi_sample <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      r_eoi_sample <= EOI_bar;
      if (Mask_Load) begin
        r_mask <= Mask_In;
      end
      if (w_ack_take) begin
        r_vec <= w_h;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: rise/fall delays describe board timing only, so the
  // synthesized outputs are driven directly whatever their values.
  // ---------------------------------------------------------------------
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_out_direct
    assign Int_bar   = w_int_bar;
    assign Y_bar     = w_y_bar;
    assign InService = r_in_service;
  end else begin : g_out_board_timed
    assign Int_bar   = w_int_bar;
    assign Y_bar     = w_y_bar;
    assign InService = r_in_service;
  end

endmodule

`default_nettype wire

// File: tb/tb_ttl_priority_interrupt_controller.sv
// ============================================================================
// tb_ttl_priority_interrupt_controller
// Directed scoreboard bench for the 8-level priority interrupt controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ttl_priority_interrupt_controller;

  logic       Clk;
  logic       Clear_bar;
  logic [7:0] Request_bar;
  logic       Mask_Load;
  logic [7:0] Mask_In;
  logic       Ack_bar;
  logic       EOI_bar;
  logic       Int_bar;
  logic [2:0] Y_bar;
  logic [7:0] InService;

  int errors = 0;
  int checks = 0;

  // Observation word: {Int_bar, Y_bar, InService}
  typedef struct {
    string      tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sb_q[$];

  ttl_priority_interrupt_controller #(
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) dut (
    .Clk         (Clk),
    .Clear_bar   (Clear_bar),
    .Request_bar (Request_bar),
    .Mask_Load   (Mask_Load),
    .Mask_In     (Mask_In),
    .Ack_bar     (Ack_bar),
    .EOI_bar     (EOI_bar),
    .Int_bar     (Int_bar),
    .Y_bar       (Y_bar),
    .InService   (InService)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic compare_head();
    sb_t         e;
    logic [11:0] obs;
    obs = {Int_bar, Y_bar, InService};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%h required=entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed Int_bar=%b Y_bar=%b InService=%h, required Int_bar=%b Y_bar=%b InService=%h",
               e.tag, obs[11], obs[10:8], obs[7:0], e.exp[11], e.exp[10:8], e.exp[7:0]);
      end
    end
  endtask

  // Push the expectation for the edge about to happen, then compare after it.
  task automatic step(input string tag, input logic [11:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    compare_head();
  endtask

  // Between-edge check, for asynchronous reset behaviour.
  task automatic check_now(input string tag, input logic [11:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    #2;
    compare_head();
  endtask

  initial begin
    Clear_bar   = 1'b1;
    Request_bar = 8'hFF;
    Mask_Load   = 1'b0;
    Mask_In     = 8'h00;
    Ack_bar     = 1'b1;
    EOI_bar     = 1'b1;

    // T1 reset asserted between edges
    #1 Clear_bar = 1'b0;
    check_now("t1_reset_async", {1'b1, 3'b111, 8'h00});
    step("t1_reset_held", {1'b1, 3'b111, 8'h00});
    Clear_bar = 1'b1;

    // T2 basic request / ack
    Mask_In = 8'h00; Mask_Load = 1'b1;
    step("t2_mask_load", {1'b1, 3'b111, 8'h00});
    Mask_Load = 1'b0; Request_bar = 8'b10100101;
    step("t2_req_edge", {1'b1, 3'b111, 8'h00});
    Request_bar = 8'hFF;
    step("t2_int", {1'b0, 3'b111, 8'h00});
    Ack_bar = 1'b0;
    step("t2_ack6", {1'b1, 3'b001, 8'h40});
    Ack_bar = 1'b1;
    step("t2_ack_release", {1'b1, 3'b111, 8'h40});
    step("t2_lower_waits", {1'b1, 3'b111, 8'h40});

    // T3 nesting of level 7 over 6, then level 4 after two EOIs
    Request_bar = 8'h7F;
    step("t3_req7", {1'b1, 3'b111, 8'h40});
    Request_bar = 8'hFF;
    step("t3_int", {1'b0, 3'b111, 8'h40});
    Ack_bar = 1'b0;
    step("t3_ack7", {1'b1, 3'b000, 8'hC0});
    Ack_bar = 1'b1;
    step("t3_ack_release", {1'b1, 3'b111, 8'hC0});
    EOI_bar = 1'b0;
    step("t3_eoi1", {1'b1, 3'b111, 8'h40});
    step("t3_eoi_held", {1'b1, 3'b111, 8'h40});
    EOI_bar = 1'b1;
    step("t3_eoi_high", {1'b1, 3'b111, 8'h40});
    EOI_bar = 1'b0;
    step("t3_eoi2", {1'b1, 3'b111, 8'h00});
    EOI_bar = 1'b1;
    step("t3_int_lvl4", {1'b0, 3'b111, 8'h00});
    Ack_bar = 1'b0;
    step("t3_ack4", {1'b1, 3'b011, 8'h10});
    Ack_bar = 1'b1;
    step("t3_ack4_release", {1'b1, 3'b111, 8'h10});

    // T5 EOI and ack at the same edge
    Request_bar = 8'hBF;
    step("t5_req6", {1'b1, 3'b111, 8'h10});
    Request_bar = 8'hFF;
    step("t5_int", {1'b0, 3'b111, 8'h10});
    Ack_bar = 1'b0; EOI_bar = 1'b0;
    step("t5_eoi_ack", {1'b1, 3'b001, 8'h40});
    Ack_bar = 1'b1; EOI_bar = 1'b1;
    step("t5_release", {1'b1, 3'b111, 8'h40});

    // Reset from a non-empty state clears all history
    Clear_bar = 1'b0;
    check_now("rst_mid_async", {1'b1, 3'b111, 8'h00});
    step("rst_mid_held", {1'b1, 3'b111, 8'h00});
    Clear_bar = 1'b1;

    // T4 masking and mask-load timing
    Mask_In = 8'h80; Mask_Load = 1'b1; Request_bar = 8'h7F;
    step("t4_load_mask80", {1'b1, 3'b111, 8'h00});
    Mask_Load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("t4_masked", {1'b1, 3'b111, 8'h00});
    end
    Mask_In = 8'h00; Mask_Load = 1'b1;
    step("t4_unmask_edge", {1'b1, 3'b111, 8'h00});
    Mask_Load = 1'b0;
    step("t4_int", {1'b0, 3'b111, 8'h00});
    Mask_In = 8'h80; Mask_Load = 1'b1;
    step("t4_remask_edge", {1'b0, 3'b111, 8'h00});
    Mask_Load = 1'b0;
    step("t4_masked_away", {1'b1, 3'b111, 8'h00});
    Mask_In = 8'h00; Mask_Load = 1'b1;
    step("t4_unmask2_edge", {1'b1, 3'b111, 8'h00});
    Mask_Load = 1'b0;
    step("t4_int2", {1'b0, 3'b111, 8'h00});
    Ack_bar = 1'b0;
    step("t4_ack7_held_req", {1'b1, 3'b000, 8'h80});
    Ack_bar = 1'b1; Request_bar = 8'hFF;
    step("t4_ack_release", {1'b1, 3'b111, 8'h80});
    EOI_bar = 1'b0;
    step("t4_eoi", {1'b1, 3'b111, 8'h00});
    EOI_bar = 1'b1;
`ifdef REQUEST_EDGE_TRIGGER_EN
    step("t4_no_repend", {1'b1, 3'b111, 8'h00});
`else
    step("t4_repend", {1'b0, 3'b111, 8'h00});
`endif

    // T6 reset in the middle of an acknowledge
    Clear_bar = 1'b0;
    check_now("t6_pre_reset_async", {1'b1, 3'b111, 8'h00});
    step("t6_pre_reset_held", {1'b1, 3'b111, 8'h00});
    Clear_bar = 1'b1;
    Mask_In = 8'h00; Mask_Load = 1'b1; Request_bar = 8'hDF;
    step("t6_req5", {1'b1, 3'b111, 8'h00});
    Mask_Load = 1'b0; Request_bar = 8'hFF;
    step("t6_int", {1'b0, 3'b111, 8'h00});
    Ack_bar = 1'b0;
    step("t6_ack5", {1'b1, 3'b010, 8'h20});
    Clear_bar = 1'b0;
    check_now("t6_async_reset", {1'b1, 3'b111, 8'h00});
    Ack_bar = 1'b1;
    step("t6_reset_held", {1'b1, 3'b111, 8'h00});
    Clear_bar = 1'b1;
    // Mask is back to all-ones: every request low must not interrupt
    Request_bar = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step("t6_mask_ff", {1'b1, 3'b111, 8'h00});
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
